// File: rtl/triangle_rasterizer_if.sv
// Bundles the triangle-FIFO read port and the pixel output stream of the rasterizer.
// The master side is the rasterizer; the slave side is the FIFO/framebuffer environment.
interface triangle_rasterizer_if #(
  parameter int COORD_W = 10
);
  logic                         tri_empty;
  logic [2:0][1:0][COORD_W-1:0] tri_in;
  logic                         tri_r_en;
  logic                         pix_valid;
  logic                         pix_ready;
  logic [COORD_W-1:0]           pix_x;
  logic [COORD_W-1:0]           pix_y;
  logic                         busy;
  logic                         tri_done;

  modport master (
    input  tri_empty, tri_in, pix_ready,
    output tri_r_en, pix_valid, pix_x, pix_y, busy, tri_done
  );

  modport slave (
    output tri_empty, tri_in, pix_ready,
    input  tri_r_en, pix_valid, pix_x, pix_y, busy, tri_done
  );
endinterface

// File: rtl/triangle_rasterizer.sv
// Pops one triangle from the FIFO, clamps its bounding box to the screen and scans it
// in raster order, emitting every covered pixel over a valid/ready stream.
module triangle_rasterizer #(
  parameter int COORD_W  = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic                   Clk,
  input logic                   Reset,
  triangle_rasterizer_if.master rif
);

  localparam int DW = COORD_W + 1;
  localparam int PW = 2 * COORD_W + 2;
  localparam int EW = 2 * COORD_W + 3;
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD, S_SCAN} state_t;

  state_t                     state;
  logic [2:0][COORD_W-1:0]    vx;
  logic [2:0][COORD_W-1:0]    vy;
  logic [COORD_W-1:0]         cx;
  logic [COORD_W-1:0]         cy;
  logic [COORD_W-1:0]         xmin;
  logic [COORD_W-1:0]         xmax;
  logic [COORD_W-1:0]         ymax;
  logic                       pix_valid_q;
  logic [COORD_W-1:0]         pix_x_q;
  logic [COORD_W-1:0]         pix_y_q;
  logic                       last_sent;

  logic [COORD_W-1:0]         ld_xmin;
  logic [COORD_W-1:0]         ld_xmax;
  logic [COORD_W-1:0]         ld_ymin;
  logic [COORD_W-1:0]         ld_ymax;
  logic signed [EW-1:0]       ld_area;
  logic                       ld_reject;
  logic signed [EW-1:0]       e0;
  logic signed [EW-1:0]       e1;
  logic signed [EW-1:0]       e2;
  logic                       covered;
  logic                       row_end;
  logic                       at_last;
  logic                       stall;
  logic                       done_c;

  // Full-precision edge function; differences and products are sized so nothing wraps.
  function automatic logic signed [EW-1:0] edge_fn(
    input logic [COORD_W-1:0] xa, ya, xb, yb, x, y
  );
    logic signed [DW-1:0] dx, dy, ex, ey;
    logic signed [PW-1:0] p0, p1;
    dx = $signed({1'b0, x})  - $signed({1'b0, xa});
    dy = $signed({1'b0, y})  - $signed({1'b0, ya});
    ex = $signed({1'b0, xb}) - $signed({1'b0, xa});
    ey = $signed({1'b0, yb}) - $signed({1'b0, ya});
    p0 = dx * ey;
    p1 = dy * ex;
    edge_fn = {p0[PW-1], p0} - {p1[PW-1], p1};
  endfunction

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    min3 = (m < c) ? m : c;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

  // Triangle setup works straight off the FIFO data during LOAD.
  always_comb begin
    ld_xmin = min3(rif.tri_in[0][0], rif.tri_in[1][0], rif.tri_in[2][0]);
    ld_ymin = min3(rif.tri_in[0][1], rif.tri_in[1][1], rif.tri_in[2][1]);
    ld_xmax = max3(rif.tri_in[0][0], rif.tri_in[1][0], rif.tri_in[2][0]);
    ld_ymax = max3(rif.tri_in[0][1], rif.tri_in[1][1], rif.tri_in[2][1]);
    if (ld_xmax > X_LIM) ld_xmax = X_LIM;
    if (ld_ymax > Y_LIM) ld_ymax = Y_LIM;
    ld_area = edge_fn(rif.tri_in[0][0], rif.tri_in[0][1], rif.tri_in[1][0],
                      rif.tri_in[1][1], rif.tri_in[2][0], rif.tri_in[2][1]);
    ld_reject = (ld_area == '0) || (ld_xmin > X_LIM) || (ld_ymin > Y_LIM);
  end

  // Both windings count as covered, and a pixel exactly on an edge is inside.
  always_comb begin
    e0 = edge_fn(vx[0], vy[0], vx[1], vy[1], cx, cy);
    e1 = edge_fn(vx[1], vy[1], vx[2], vy[2], cx, cy);
    e2 = edge_fn(vx[2], vy[2], vx[0], vy[0], cx, cy);
    covered = (!e0[EW-1] && !e1[EW-1] && !e2[EW-1]) ||
              ((e0[EW-1] || e0 == '0) && (e1[EW-1] || e1 == '0) && (e2[EW-1] || e2 == '0));
    row_end = (cx == xmax);
    at_last = row_end && (cy == ymax);
    stall   = pix_valid_q && !rif.pix_ready;
  end

  always_comb begin
    done_c = 1'b0;
    case (state)
      S_LOAD:  done_c = ld_reject;
      S_SCAN:  done_c = last_sent ? rif.pix_ready : (!stall && at_last && !covered);
      default: done_c = 1'b0;
    endcase
  end

  assign rif.tri_r_en  = (state == S_IDLE) && !rif.tri_empty && !Reset;
  assign rif.busy      = (state != S_IDLE);
  assign rif.tri_done  = done_c;
  assign rif.pix_valid = pix_valid_q;
  assign rif.pix_x     = pix_x_q;
  assign rif.pix_y     = pix_y_q;

  // Once the last covered pixel is issued, SCAN lingers only until it is accepted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      vx          <= '0;
      vy          <= '0;
      cx          <= '0;
      cy          <= '0;
      xmin        <= '0;
      xmax        <= '0;
      ymax        <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      last_sent   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rif.tri_r_en) state <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          for (int v = 0; v < 3; v++) begin
            vx[v] <= rif.tri_in[v][0];
            vy[v] <= rif.tri_in[v][1];
          end
          xmin      <= ld_xmin;
          xmax      <= ld_xmax;
          ymax      <= ld_ymax;
          cx        <= ld_xmin;
          cy        <= ld_ymin;
          last_sent <= 1'b0;
          state     <= ld_reject ? S_IDLE : S_SCAN;
        end
        S_SCAN: begin
          if (last_sent) begin
            if (rif.pix_ready) begin
              pix_valid_q <= 1'b0;
              last_sent   <= 1'b0;
              state       <= S_IDLE;
            end
          end else if (!stall) begin
            pix_valid_q <= covered;
            if (covered) begin
              pix_x_q <= cx;
              pix_y_q <= cy;
            end
            if (at_last) begin
              if (covered) last_sent <= 1'b1;
              else         state     <= S_IDLE;
            end else if (row_end) begin
              cx <= xmin;
              cy <= cy + 1'b1;
            end else begin
              cx <= cx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
